// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory access per EX instruction, with
// alignment/legality checks, store lane steering, load formatting and an ack timeout.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3Q;
  logic [1:0]    offQ;
  logic          loadQ;

  logic          memop;
  logic          bad;
  logic [3:0]    strb;
  logic [31:0]   wdata;
  logic [31:0]   shifted;
  logic [7:0]    byteV;
  logic [15:0]   halfV;
  logic [31:0]   loadFmt;

  assign memop = ex_valid & (mem_read | mem_write);
  assign stall = memop & (state != DONE);

  // Legality and alignment of the instruction currently presented by EX
  always_comb begin
    bad = 1'b0;
    if (mem_read & mem_write) begin
      bad = 1'b1;
    end else if (mem_read) begin
      case (funct3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = addr_in[0];
        3'b010:         bad = |addr_in[1:0];
        default:        bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = addr_in[0];
        3'b010:  bad = |addr_in[1:0];
        default: bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    strb  = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        strb  = 4'b0001 << addr_in[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << addr_in[1:0];
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Lane selection uses the byte offset captured at accept time
  always_comb begin
    shifted = mem_rdata >> {offQ, 3'b000};
    byteV   = shifted[7:0];
    halfV   = offQ[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3Q)
      3'b000:  loadFmt = {{24{byteV[7]}}, byteV};
      3'b100:  loadFmt = {24'b0, byteV};
      3'b001:  loadFmt = {{16{halfV[15]}}, halfV};
      3'b101:  loadFmt = {16'b0, halfV};
      default: loadFmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      f3Q       <= '0;
      offQ      <= '0;
      loadQ     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      lsu_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_valid <= 1'b0;
          lsu_err  <= 1'b0;
          if (memop) begin
            if (bad) begin
              state   <= DONE;
              lsu_err <= 1'b1;
              wb_data <= '0;
            end else begin
              state     <= ACCESS;
              cnt       <= '0;
              f3Q       <= funct3;
              offQ      <= addr_in[1:0];
              loadQ     <= mem_read;
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {addr_in[31:2], 2'b00};
              mem_wdata <= wdata;
              mem_wstrb <= mem_write ? strb : 4'b0000;
            end
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle still wins over the timeout
          if (mem_ack) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            wb_valid <= loadQ;
            wb_data  <= loadQ ? loadFmt : 32'h0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state   <= DONE;
            mem_req <= 1'b0;
            lsu_err <= 1'b1;
            wb_data <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          wb_valid <= 1'b0;
          lsu_err  <= 1'b0;
          wb_data  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr_in, store_data;
  logic        stall, wb_valid, lsu_err;
  logic [31:0] wb_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr_in(addr_in),
    .store_data(store_data), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .lsu_err(lsu_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: result of one memory instruction from the ISA rules
  function automatic logic modelIllegal(input logic rd, input logic wr, input logic [2:0] f3,
                                        input logic [31:0] addr);
    int size;
    if (rd && wr) return 1'b1;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    size = 1 << f3[1:0];
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0] v;
    int off;
    off = addr % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (8 * (off - off % 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] addr);
    int off;
    off = addr % 4;
    case (f3[1:0])
      2'd0:    return 4'(1 << off);
      2'd1:    return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] b, h;
    b = sd & 32'hFF;
    h = sd & 32'hFFFF;
    case (f3[1:0])
      2'd0:    return b * 32'h01010101;
      2'd1:    return h * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  // One instruction: ack arrives in ACCESS cycle ackDelay+1 unless the timeout hits first
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sd,
                               input logic [31:0] rdata, input int ackDelay, input logic dropValid);
    logic        err, timedOut, expValid;
    int          reqCycles, expStall;
    logic [31:0] expData;
    err       = modelIllegal(rd, wr, f3, addr);
    timedOut  = !err && (ackDelay + 1 > TO);
    reqCycles = err ? 0 : ((ackDelay + 1 > TO) ? TO : ackDelay + 1);
    expStall  = 1 + reqCycles;
    expValid  = rd && !err && !timedOut;
    expData   = expValid ? modelLoad(f3, addr, rdata) : 32'h0;

    @(negedge clk);
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    addr_in = addr; store_data = sd; mem_rdata = rdata; mem_ack = 1'b0;
    #1;
    checkOutput("stall_idle", stall, 1);
    checkOutput("req_idle", mem_req, 0);

    for (int idx = 1; idx < expStall; idx++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      checkOutput("req_access", mem_req, 1);
      checkOutput("addr", mem_addr, addr & 32'hFFFFFFFC);
      checkOutput("we", mem_we, wr);
      checkOutput("wstrb", mem_wstrb, wr ? modelStrb(f3, addr) : 4'h0);
      if (wr) checkOutput("wdata", mem_wdata, modelWdata(f3, sd));
      checkOutput("wbvalid_access", wb_valid, 0);
      checkOutput("err_access", lsu_err, 0);
      checkOutput("stall_access", stall, ex_valid);
      if (dropValid && idx == 1) ex_valid = 1'b0;
      if (idx == ackDelay + 1) mem_ack = 1'b1;
    end

    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("req_done", mem_req, 0);
    checkOutput("stall_done", stall, 0);
    checkOutput("wbvalid_done", wb_valid, expValid);
    checkOutput("wbdata_done", wb_data, expData);
    checkOutput("err_done", lsu_err, err || timedOut);
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;

    @(posedge clk); #1;
    checkOutput("wbvalid_after", wb_valid, 0);
    checkOutput("err_after", lsu_err, 0);
    checkOutput("req_after", mem_req, 0);
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr_in = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_wstrb", mem_wstrb, 0);
    checkOutput("rst_wbvalid", wb_valid, 0);
    checkOutput("rst_wbdata", wb_data, 0);
    checkOutput("rst_err", lsu_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    applyStimulus(1, 0, 3'd2, 32'h104, 32'h0, 32'hDEADBEEF, 2, 0);
    applyStimulus(1, 0, 3'd0, 32'h203, 32'h0, 32'h80FF1234, 0, 0);
    applyStimulus(1, 0, 3'd4, 32'h203, 32'h0, 32'h80FF1234, 1, 0);
    applyStimulus(0, 1, 3'd1, 32'h302, 32'h0000ABCD, 32'h0, 0, 0);
    applyStimulus(1, 0, 3'd2, 32'h101, 32'h0, 32'h12345678, 0, 0);
    applyStimulus(1, 0, 3'd2, 32'h500, 32'h0, 32'h12345678, 10, 0);
    applyStimulus(1, 0, 3'd1, 32'h502, 32'h0, 32'h8001_7FFF, 3, 0);
    applyStimulus(0, 1, 3'd0, 32'h601, 32'h000000A5, 32'h0, 1, 1);
    applyStimulus(1, 1, 3'd2, 32'h700, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 1, 3'd4, 32'h700, 32'h0, 32'h0, 0, 0);

    // Reset during the second ACCESS cycle, then a back-to-back LW
    @(negedge clk);
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2;
    addr_in = 32'h400; mem_ack = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstmid_req1", mem_req, 1);
    @(posedge clk); #1;
    checkOutput("rstmid_req2", mem_req, 1);
    rst = 1'b0;
    #1;
    checkOutput("rstmid_req_async", mem_req, 0);
    checkOutput("rstmid_addr", mem_addr, 0);
    ex_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstmid_req_hold", mem_req, 0);
    rst = 1'b1;
    applyStimulus(1, 0, 3'd2, 32'h408, 32'h0, 32'hCAFEF00D, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic        rd, wr, drop;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          sel, delay;
      sel = $urandom_range(0, 19);
      rd  = (sel < 9) || (sel >= 18);
      wr  = (sel >= 9);
      if ($urandom_range(0, 9) < 8) begin
        if (rd && !wr) f3 = 3'($urandom_range(0, 4) == 4 ? 5 : $urandom_range(0, 4));
        else           f3 = 3'($urandom_range(0, 2));
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 1);
      delay = $urandom_range(0, TO + 1);
      drop  = ($urandom_range(0, 4) == 0) && !modelIllegal(rd, wr, f3, addr);
      applyStimulus(rd, wr, f3, addr, $urandom, $urandom, delay, drop);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, which sets the maximum number of ACCESS cycles spent waiting for mem_ack.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port ex_valid, input, 1 bit: the EX-stage instruction is valid.
REQ-005 SHALL have ports mem_read and mem_write, input, 1 bit each: the EX instruction is a load or a store.
REQ-006 SHALL have port funct3, input, 3 bits: access size and sign.
REQ-007 SHALL have port addr_in, input, 32 bits: byte address, taken from the ALU result.
REQ-008 SHALL have port store_data, input, 32 bits: the rs2 value.
REQ-009 SHALL have port stall, output, 1 bit: the pipeline holds EX and earlier stages.
REQ-010 SHALL have port wb_valid, output, 1 bit: a load result is present on wb_data.
REQ-011 SHALL have port wb_data, output, 32 bits: the formatted load result.
REQ-012 SHALL have port lsu_err, output, 1 bit: the access was misaligned, illegal or timed out.
REQ-013 SHALL have memory-side ports: mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32, word-aligned), mem_wdata (out, 32), mem_wstrb (out, 4), mem_ack (in, 1), mem_rdata (in, 32).

Function
REQ-014 SHALL implement an FSM with three states: IDLE, ACCESS and DONE.
REQ-015 SHALL define memop = ex_valid & (mem_read | mem_write), and stall = memop & (state != DONE), driven combinationally.
REQ-016 In IDLE with memop, SHALL on the next edge register the operands, compute mem_addr = {addr_in[31:2], 2'b00}, and go to ACCESS.
REQ-017 In IDLE, SHALL instead go directly to DONE with lsu_err=1 and no mem_req when any of the following holds: mem_read & mem_write; an illegal funct3 (load: not 000/001/010/100/101; store: not 000/001/010); a halfword with addr_in[0]=1; a word with addr_in[1:0]!=0.
REQ-018 In ACCESS, SHALL hold mem_req=1 with mem_addr, mem_we, mem_wdata and mem_wstrb stable until mem_ack is sampled high.
REQ-019 On mem_ack in ACCESS, SHALL capture mem_rdata (loads only), clear mem_req on the same edge, and go to DONE.
REQ-020 SHALL count ACCESS cycles without ack; after TIMEOUT such cycles it SHALL drop mem_req and go to DONE with lsu_err=1 and wb_data=0.
REQ-021 A mem_ack arriving in the cycle the count reaches TIMEOUT SHALL take priority over the timeout.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; the still-present EX instruction SHALL NOT be re-accepted in DONE.
REQ-023 In DONE, SHALL assert wb_valid=1 only for loads without error; lsu_err is valid in DONE only; both SHALL be 0 in all other states.
REQ-024 Store strobes SHALL be: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111.
REQ-025 Store data SHALL be: SB byte replicated into all 4 lanes, SH halfword replicated into both halves, SW unchanged.
REQ-026 mem_we SHALL be 1 for stores; mem_wstrb SHALL be 0 for loads.
REQ-027 Load formatting SHALL select the byte/halfword lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-028 Minimum latency SHALL be: accept edge to DONE = 2 cycles when ack arrives in the first ACCESS cycle; error-in-IDLE to DONE = 1 cycle.
REQ-029 ex_valid falling while in ACCESS SHALL NOT abort the access; the access completes normally.

Reset
REQ-030 While rst=0, the block SHALL be in IDLE, with the timeout counter at 0 and all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid, wb_data, lsu_err).
REQ-031 Assertion of rst mid-ACCESS SHALL drop mem_req immediately, without waiting for a clock edge, and discard the pending access.
REQ-032 After rst deasserts, the first memop SHALL be accepted on the first rising edge.

Verification
REQ-033 LW: addr_in=0x104, mem_rdata=0xDEADBEEF, ack in 3rd ACCESS cycle -> mem_addr=0x104, stall high for 4 cycles, DONE: wb_valid=1, wb_data=0xDEADBEEF.
REQ-034 LB/LBU: addr_in=0x203, mem_rdata=0x80FF1234 -> LB gives wb_data=0xFFFFFF80; LBU gives 0x00000080.
REQ-035 SH: addr_in=0x302, store_data=0x0000ABCD -> mem_we=1, mem_wstrb=1100, mem_wdata=0xABCDABCD, wb_valid=0 in DONE.
REQ-036 Misaligned LW: addr_in=0x101 -> no mem_req ever asserted, DONE next cycle with lsu_err=1, stall low in the DONE cycle.
REQ-037 Timeout: TIMEOUT=4, no ack -> mem_req high for exactly 4 cycles, then DONE with lsu_err=1 and wb_data=0.
REQ-038 Reset: rst=0 in the 2nd ACCESS cycle -> mem_req=0 before the next edge; after release, an LW with ack in the 1st cycle completes with 2-cycle latency.
